// File: rtl/upower_main_control_if.sv
// ============================================================================
// Module   : upower_main_control_if
// Purpose  : Instruction, decode-field, strobe and data-memory handshake
//            bundle of the uPower main controller.
//            Optional macro UPOWER_PERF_CNT_EN adds the instret signal.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface upower_main_control_if #(
  parameter int CNT_W = 32
);
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [1:0]  ALUop;
  logic [9:0]  xox;
  logic [8:0]  xoxo;
  logic [1:0]  xods;
  logic        ALUSrc;
  logic        alu_en;
  logic        Branch;
  logic        MemRead;
  logic        MemWrite;
  logic        mem_req;
  logic        mem_ack;
  logic        MemtoReg;
  logic        RegWrite;
  logic        done;
  logic        err;

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

`ifdef UPOWER_PERF_CNT_EN
  logic [CNT_W-1:0] instret;

  modport master (
    input  instr, instr_valid, mem_ack,
    output instr_ready, ALUop, xox, xoxo, xods, ALUSrc, alu_en, Branch,
           MemRead, MemWrite, mem_req, MemtoReg, RegWrite, done, err, instret
  );
  modport slave (
    output instr, instr_valid, mem_ack,
    input  instr_ready, ALUop, xox, xoxo, xods, ALUSrc, alu_en, Branch,
           MemRead, MemWrite, mem_req, MemtoReg, RegWrite, done, err, instret
  );
`else
  modport master (
    input  instr, instr_valid, mem_ack,
    output instr_ready, ALUop, xox, xoxo, xods, ALUSrc, alu_en, Branch,
           MemRead, MemWrite, mem_req, MemtoReg, RegWrite, done, err
  );
  modport slave (
    output instr, instr_valid, mem_ack,
    input  instr_ready, ALUop, xox, xoxo, xods, ALUSrc, alu_en, Branch,
           MemRead, MemWrite, mem_req, MemtoReg, RegWrite, done, err
  );
`endif

endinterface

`default_nettype wire

// File: rtl/upower_main_control.sv
// ============================================================================
// Module   : upower_main_control
// Purpose  : Multi-cycle DECODE/EXEC/MEM/WB control FSM feeding ALU_Control.
//            Optional macro UPOWER_PERF_CNT_EN adds a retired-instruction count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module upower_main_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  upower_main_control_if.master bus
);

  localparam int TW = $clog2(MEM_TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERR
  } state_t;

  typedef enum logic [2:0] {
    C_ALU, C_IMM, C_LOAD, C_STORE, C_BR, C_ILL
  } cls_t;

  if (MEM_TIMEOUT < 2 || CNT_W < 1) begin : g_param_check
    $error("MEM_TIMEOUT must be >= 2 and CNT_W >= 1");
  end

  state_t          r_state, w_state_nxt;
  cls_t            w_cls;
  logic [5:0]      r_opcode;
  logic [10:0]     r_low;
  logic [1:0]      r_aluop, w_aluop;
  logic            r_alusrc, w_alusrc;
  logic [9:0]      r_xox;
  logic [8:0]      r_xoxo;
  logic [1:0]      r_xods;
  logic [TW-1:0]   r_tcnt;

  always_comb begin
    w_cls    = C_ILL;
    w_aluop  = 2'b00;
    w_alusrc = 1'b0;
    case (r_opcode)
      6'd31:        begin w_cls = C_ALU;   w_aluop = 2'b10; end
      6'd14:        begin w_cls = C_IMM;   w_alusrc = 1'b1; end
      6'd32, 6'd58: begin w_cls = C_LOAD;  w_alusrc = 1'b1; end
      6'd36, 6'd62: begin w_cls = C_STORE; w_alusrc = 1'b1; end
      6'd18, 6'd16: begin w_cls = C_BR;    w_aluop = 2'b01; end
      default:      ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_opcode <= '0;
      r_low    <= '0;
      r_aluop  <= '0;
      r_alusrc <= 1'b0;
      r_xox    <= '0;
      r_xoxo   <= '0;
      r_xods   <= '0;
      r_tcnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && bus.instr_valid) begin
        r_opcode <= bus.instr[31:26];
        r_low    <= bus.instr[10:0];
      end
      if (r_state == S_DECODE) begin
        r_aluop  <= w_aluop;
        r_alusrc <= w_alusrc;
        r_xox    <= r_low[10:1];
        r_xoxo   <= r_low[9:1];
        r_xods   <= r_low[1:0];
      end
      // Cleared everywhere outside MEM so every MEM visit starts from zero.
      r_tcnt <= (r_state == S_MEM) ? r_tcnt + 1'b1 : '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (bus.instr_valid) w_state_nxt = S_DECODE;
      S_DECODE: w_state_nxt = (w_cls == C_ILL) ? S_ERR : S_EXEC;
      S_EXEC: begin
        if (w_cls == C_LOAD || w_cls == C_STORE) w_state_nxt = S_MEM;
        else if (w_cls == C_BR)                  w_state_nxt = S_IDLE;
        else                                     w_state_nxt = S_WB;
      end
      S_MEM: begin
        if (bus.mem_ack)           w_state_nxt = (w_cls == C_LOAD) ? S_WB : S_IDLE;
        else if (r_tcnt == TO_LAST) w_state_nxt = S_ERR;
      end
      S_WB:     w_state_nxt = S_IDLE;
      S_ERR:    w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.instr_ready = (r_state == S_IDLE);
    bus.alu_en      = (r_state == S_EXEC);
    bus.Branch      = (r_state == S_EXEC) && (w_cls == C_BR);
    bus.mem_req     = (r_state == S_MEM);
    bus.MemRead     = (r_state == S_MEM) && (w_cls == C_LOAD);
    bus.MemWrite    = (r_state == S_MEM) && (w_cls == C_STORE);
    bus.MemtoReg    = (r_state == S_WB) && (w_cls == C_LOAD);
    bus.RegWrite    = (r_state == S_WB);
    bus.err         = (r_state == S_ERR);
    bus.done        = (r_state == S_WB)
                    || ((r_state == S_EXEC) && (w_cls == C_BR))
                    || ((r_state == S_MEM) && (w_cls == C_STORE) && bus.mem_ack);
  end

  assign bus.ALUop  = r_aluop;
  assign bus.ALUSrc = r_alusrc;
  assign bus.xox    = r_xox;
  assign bus.xoxo   = r_xoxo;
  assign bus.xods   = r_xods;

`ifdef UPOWER_PERF_CNT_EN
  logic [CNT_W-1:0] r_instret;

  always_ff @(posedge clk) begin
    if (rst)           r_instret <= '0;
    else if (bus.done) r_instret <= r_instret + 1'b1;
  end

  assign bus.instret = r_instret;
`endif

endmodule

`default_nettype wire

// File: tb/tb_upower_main_control.sv
// ============================================================================
// Module   : tb_upower_main_control
// Purpose  : Directed self-checking bench for upower_main_control.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_upower_main_control;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  upower_main_control_if #(.CNT_W(32)) bus ();

  upower_main_control #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {instr_ready, alu_en, Branch, MemRead, MemWrite, mem_req, MemtoReg, RegWrite, done, err}
  logic [9:0] strb;
  assign strb = {bus.instr_ready, bus.alu_en, bus.Branch, bus.MemRead, bus.MemWrite,
                 bus.mem_req, bus.MemtoReg, bus.RegWrite, bus.done, bus.err};

  localparam logic [9:0] ST_IDLE    = 10'b1000000000;
  localparam logic [9:0] ST_NONE    = 10'b0000000000;
  localparam logic [9:0] ST_EXEC    = 10'b0100000000;
  localparam logic [9:0] ST_EXEC_BR = 10'b0110000010;
  localparam logic [9:0] ST_WB      = 10'b0000000110;
  localparam logic [9:0] ST_WB_LD   = 10'b0000001110;
  localparam logic [9:0] ST_MEM_LD  = 10'b0001010000;
  localparam logic [9:0] ST_MEM_ST  = 10'b0000110000;
  localparam logic [9:0] ST_MEM_STA = 10'b0000110010;
  localparam logic [9:0] ST_ERR     = 10'b0000000001;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [31:0] word);
    bus.instr       = word;
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    chk("decode_strobes", 32'(strb), 32'(ST_NONE));
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    rst             = 1'b1;
    bus.instr       = '0;
    bus.instr_valid = 1'b0;
    bus.mem_ack     = 1'b0;
    tick();
    tick();
    chk("reset_strobes", 32'(strb), 32'(ST_IDLE));
    chk("reset_fields", {bus.ALUop, bus.ALUSrc, bus.xox, bus.xoxo, bus.xods}, 32'd0);
`ifdef UPOWER_PERF_CNT_EN
    chk("reset_instret", bus.instret, 32'd0);
`endif
    rst = 1'b0;
    tick();
    chk("idle_strobes", 32'(strb), 32'(ST_IDLE));

    // add r1,r2,r3
    accept(32'h7C22_1A14);
    tick();
    chk("add_exec", 32'(strb), 32'(ST_EXEC));
    chk("add_aluop", 32'(bus.ALUop), 32'd2);
    chk("add_xoxo", 32'(bus.xoxo), 32'h10A);
    chk("add_alusrc", 32'(bus.ALUSrc), 32'd0);
    tick();
    chk("add_wb", 32'(strb), 32'(ST_WB));
    tick();
    chk("add_idle", 32'(strb), 32'(ST_IDLE));

    // and, with a competing instruction offered while busy
    accept(32'h7C41_1838);
    bus.instr       = 32'h0000_0000;
    bus.instr_valid = 1'b1;
    tick();
    chk("and_exec", 32'(strb), 32'(ST_EXEC));
    chk("and_xox", 32'(bus.xox), 32'h01C);
    chk("and_aluop", 32'(bus.ALUop), 32'd2);
    tick();
    chk("and_wb", 32'(strb), 32'(ST_WB));
    bus.instr_valid = 1'b0;
    tick();
    chk("and_idle", 32'(strb), 32'(ST_IDLE));
    chk("and_xox_hold", 32'(bus.xox), 32'h01C);

    // addi with mem_ack asserted outside MEM
    accept(32'h3821_0001);
    bus.mem_ack = 1'b1;
    tick();
    chk("addi_exec", 32'(strb), 32'(ST_EXEC));
    chk("addi_ctl", {28'd0, bus.ALUop, bus.ALUSrc, 1'b0}, {28'd0, 2'b00, 1'b1, 1'b0});
    chk("addi_xods", 32'(bus.xods), 32'd1);
    tick();
    chk("addi_wb", 32'(strb), 32'(ST_WB));
    bus.mem_ack = 1'b0;
    tick();
    chk("addi_idle", 32'(strb), 32'(ST_IDLE));

    // b: done straight from EXEC
    accept(32'h4800_0010);
    tick();
    chk("br_exec", 32'(strb), 32'(ST_EXEC_BR));
    chk("br_aluop", 32'(bus.ALUop), 32'd1);
    tick();
    chk("br_idle", 32'(strb), 32'(ST_IDLE));

    // ld r1,8(r2): ack on third MEM cycle
    accept(32'hE822_0008);
    tick();
    chk("ld_exec", 32'(strb), 32'(ST_EXEC));
    chk("ld_fields", {bus.ALUop, bus.ALUSrc, bus.xox, bus.xods}, {17'd0, 2'b00, 1'b1, 10'h004, 2'b00});
    tick();
    chk("ld_mem1", 32'(strb), 32'(ST_MEM_LD));
    tick();
    chk("ld_mem2", 32'(strb), 32'(ST_MEM_LD));
    tick();
    bus.mem_ack = 1'b1;
    #1;
    chk("ld_mem3", 32'(strb), 32'(ST_MEM_LD));
    tick();
    bus.mem_ack = 1'b0;
    chk("ld_wb", 32'(strb), 32'(ST_WB_LD));
    tick();
    chk("ld_idle", 32'(strb), 32'(ST_IDLE));

    // stw: ack on the first MEM cycle retires in that cycle
    accept(32'h9022_0004);
    tick();
    chk("stw_exec", 32'(strb), 32'(ST_EXEC));
    tick();
    chk("stw_mem", 32'(strb), 32'(ST_MEM_ST));
    bus.mem_ack = 1'b1;
    #1;
    chk("stw_mem_ack", 32'(strb), 32'(ST_MEM_STA));
    tick();
    bus.mem_ack = 1'b0;
    chk("stw_idle", 32'(strb), 32'(ST_IDLE));

    // illegal opcode 0
    accept(32'h0000_0000);
    tick();
    chk("ill_err", 32'(strb), 32'(ST_ERR));
    tick();
    chk("ill_idle", 32'(strb), 32'(ST_IDLE));

    // std with no ack: timeout after 16 MEM cycles
    accept(32'hF822_0000);
    tick();
    chk("std_exec", 32'(strb), 32'(ST_EXEC));
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("std_mem", 32'(strb), 32'(ST_MEM_ST));
    end
    tick();
    chk("std_timeout_err", 32'(strb), 32'(ST_ERR));
    tick();
    chk("std_idle", 32'(strb), 32'(ST_IDLE));
`ifdef UPOWER_PERF_CNT_EN
    chk("instret_count", bus.instret, 32'd6);
`endif

    // reset in the middle of a load's MEM phase
    accept(32'hE822_0008);
    tick();
    tick();
    chk("rst_ld_mem", 32'(strb), 32'(ST_MEM_LD));
    rst = 1'b1;
    tick();
    chk("rst_idle", 32'(strb), 32'(ST_IDLE));
`ifdef UPOWER_PERF_CNT_EN
    chk("rst_instret", bus.instret, 32'd0);
`endif
    rst = 1'b0;
    tick();
    chk("post_rst_idle", 32'(strb), 32'(ST_IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
